// File: rtl/tempo_display.sv
// Converts the 7-bit tempo count to three BCD digits with a serial shift-add-3
// engine and drives a multiplexed 3-digit active-low seven-segment display.
module tempo_display #(
   parameter int SCAN_BITS   = 16,
   parameter bit BLANK_ZEROS = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  tempo,
   output logic [11:0] bcd,
   output logic        valid,
   output logic [2:0]  an,
   output logic [6:0]  seg
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t                 state;
   logic [6:0]             last_tempo;
   logic                   force_load;
   logic [2:0]             shift_cnt;
   logic [18:0]            shreg;
   logic [18:0]            adj;
   logic [SCAN_BITS-1:0]   presc;
   logic [1:0]             digit_idx;
   logic [3:0]             cur_nibble;
   logic [2:0]             cur_an;
   logic                   cur_blank;

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      case (d)
         4'd0:    seg_decode = 7'b1000000;
         4'd1:    seg_decode = 7'b1111001;
         4'd2:    seg_decode = 7'b0100100;
         4'd3:    seg_decode = 7'b0110000;
         4'd4:    seg_decode = 7'b0011001;
         4'd5:    seg_decode = 7'b0010010;
         4'd6:    seg_decode = 7'b0000010;
         4'd7:    seg_decode = 7'b1111000;
         4'd8:    seg_decode = 7'b0000000;
         4'd9:    seg_decode = 7'b0010000;
         default: seg_decode = 7'b1111111;
      endcase
   endfunction

   // Add-3 correction on each BCD nibble that would overflow past 9 after the shift.
   always_comb begin
      adj = shreg;
      for (int i = 0; i < 3; i++) begin
         if (shreg[7+4*i +: 4] >= 4'd5)
            adj[7+4*i +: 4] = shreg[7+4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         force_load <= 1'b1;
         last_tempo <= 7'd0;
         shift_cnt  <= 3'd0;
         shreg      <= 19'd0;
         bcd        <= 12'h000;
         valid      <= 1'b0;
      end else begin
         valid <= 1'b0;
         case (state)
            IDLE: begin
               if (force_load || (tempo != last_tempo)) begin
                  shreg      <= {12'h000, tempo};
                  last_tempo <= tempo;
                  force_load <= 1'b0;
                  shift_cnt  <= 3'd0;
                  state      <= SHIFT;
               end
            end
            SHIFT: begin
               shreg     <= adj << 1;
               shift_cnt <= shift_cnt + 3'd1;
               if (shift_cnt == 3'd6)
                  state <= DONE;
            end
            DONE: begin
               bcd   <= shreg[18:7];
               valid <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc     <= '0;
         digit_idx <= 2'd0;
      end else begin
         presc <= presc + {{(SCAN_BITS-1){1'b0}}, 1'b1};
         if (&presc)
            digit_idx <= (digit_idx == 2'd2) ? 2'd0 : digit_idx + 2'd1;
      end
   end

   // Leading-zero blanking keeps the digit enable asserted but darkens all segments.
   always_comb begin
      cur_nibble = bcd[3:0];
      cur_an     = 3'b110;
      cur_blank  = 1'b0;
      case (digit_idx)
         2'd1: begin
            cur_nibble = bcd[7:4];
            cur_an     = 3'b101;
            cur_blank  = BLANK_ZEROS && (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0);
         end
         2'd2: begin
            cur_nibble = bcd[11:8];
            cur_an     = 3'b011;
            cur_blank  = BLANK_ZEROS && (bcd[11:8] == 4'd0);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an  <= 3'b110;
         seg <= 7'b1000000;
      end else begin
         an  <= cur_an;
         seg <= cur_blank ? 7'b1111111 : seg_decode(cur_nibble);
      end
   end

endmodule

// File: tb/tb_tempo_display.sv
// Bench for tempo_display: directed and randomized tempo sequences checked against
// an arithmetic model of capture timing, BCD value and display scanning.
module tb_tempo_display;

   localparam int SCAN   = 2;
   localparam int PERIOD = 1 << SCAN;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [6:0]  tempo;
   logic [11:0] bcd, bcd_nb;
   logic        valid, valid_nb;
   logic [2:0]  an, an_nb;
   logic [6:0]  seg, seg_nb;

   int nCompared   = 0;
   int nMismatched = 0;

   int k, lastT, nextAllowed, dueEdge, dueVal, bcdVal, dispVal, lastValidK;
   bit forced, expValid;

   logic [6:0] segTab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

   tempo_display #(.SCAN_BITS(SCAN), .BLANK_ZEROS(1'b1)) u_dut (
      .clk(clk), .rst_n(rst_n), .tempo(tempo),
      .bcd(bcd), .valid(valid), .an(an), .seg(seg)
   );

   tempo_display #(.SCAN_BITS(SCAN), .BLANK_ZEROS(1'b0)) u_dut_nb (
      .clk(clk), .rst_n(rst_n), .tempo(tempo),
      .bcd(bcd_nb), .valid(valid_nb), .an(an_nb), .seg(seg_nb)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] toBcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic logic [2:0] anFor(input int idx);
      logic [2:0] one;
      one = 3'b001;
      return ~(one << idx);
   endfunction

   function automatic logic [6:0] segFor(input int idx, input int v, input bit blankZ);
      int h, t, u, d;
      bit blank;
      h = v / 100;
      t = (v / 10) % 10;
      u = v % 10;
      d = (idx == 0) ? u : (idx == 1) ? t : h;
      blank = blankZ && (((idx == 2) && (h == 0)) || ((idx == 1) && (h == 0) && (t == 0)));
      return blank ? 7'b1111111 : segTab[d];
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCompared++;
      assert (obs === exp) else begin
         nMismatched++;
         $error("[TB] FAIL %s at edge %0d: observed=%0h expected=%0h", tag, k, obs, exp);
      end
   endtask

   task automatic modelReset();
      k           = 0;
      forced      = 1'b1;
      lastT       = 0;
      nextAllowed = 1;
      dueEdge     = -1;
      dueVal      = 0;
      bcdVal      = 0;
      dispVal     = 0;
      expValid    = 1'b0;
      lastValidK  = -1;
   endtask

   // Capture is allowed at most once per 9 edges; the result lands 8 edges later.
   task automatic modelStep(input int t);
      k++;
      dispVal  = bcdVal;
      expValid = 1'b0;
      if (dueEdge == k) begin
         expValid = 1'b1;
         bcdVal   = dueVal;
         dueEdge  = -1;
      end
      if ((k >= nextAllowed) && (forced || (t != lastT))) begin
         forced      = 1'b0;
         lastT       = t;
         dueEdge     = k + 8;
         dueVal      = t;
         nextAllowed = k + 9;
      end
   endtask

   task automatic checkAll();
      int idx;
      idx = ((k - 1) / PERIOD) % 3;
      checkOutput("valid", 32'(valid), 32'(expValid));
      checkOutput("bcd", 32'(bcd), 32'(toBcd(bcdVal)));
      checkOutput("an", 32'(an), 32'(anFor(idx)));
      checkOutput("seg", 32'(seg), 32'(segFor(idx, dispVal, 1'b1)));
      checkOutput("bcd_nb", 32'(bcd_nb), 32'(toBcd(bcdVal)));
      checkOutput("an_nb", 32'(an_nb), 32'(anFor(idx)));
      checkOutput("seg_nb", 32'(seg_nb), 32'(segFor(idx, dispVal, 1'b0)));
   endtask

   task automatic checkReset();
      checkOutput("rst_bcd", 32'(bcd), 32'h000);
      checkOutput("rst_valid", 32'(valid), 32'h0);
      checkOutput("rst_an", 32'(an), 32'(3'b110));
      checkOutput("rst_seg", 32'(seg), 32'(7'b1000000));
      checkOutput("rst_seg_nb", 32'(seg_nb), 32'(7'b1000000));
      checkOutput("rst_valid_nb", 32'(valid_nb), 32'h0);
   endtask

   task automatic tick();
      int sampled;
      sampled = int'(tempo);
      @(posedge clk);
      #1;
      modelStep(sampled);
      checkAll();
   endtask

   task automatic applyStimulus(input int t, input int n);
      tempo = 7'(t);
      repeat (n) tick();
   endtask

   task automatic applyReset(input int t);
      rst_n = 1'b0;
      tempo = 7'(t);
      @(negedge clk);
      @(negedge clk);
      checkReset();
      rst_n = 1'b1;
      modelReset();
   endtask

   initial begin
      int t;
      rst_n = 1'b0;
      tempo = 7'd0;
      modelReset();

      $display("[TB] reset release with tempo=0");
      applyReset(0);
      applyStimulus(0, 30);

      $display("[TB] boundary values held from reset");
      applyReset(127);
      applyStimulus(127, 20);
      applyReset(100);
      applyStimulus(100, 20);
      applyReset(9);
      applyStimulus(9, 20);

      $display("[TB] display scan with tempo=89");
      applyReset(89);
      applyStimulus(89, 40);

      $display("[TB] tempo change during conversion");
      applyReset(5);
      applyStimulus(5, 3);
      applyStimulus(6, 20);

      $display("[TB] free-running upstream counter across wrap");
      t = $urandom_range(90, 120);
      applyReset(t);
      for (int i = 0; i < 200; i++) begin
         applyStimulus(t, 1);
         if (valid === 1'b1) begin
            if (lastValidK > 0)
               checkOutput("valid_gap", 32'(k - lastValidK), 32'd9);
            lastValidK = k;
         end
         t = (t + 1) % 128;
      end

      $display("[TB] reset asserted during conversion");
      t = $urandom_range(0, 127);
      applyReset(t);
      applyStimulus(t, 4);
      rst_n = 1'b0;
      #2;
      checkReset();
      applyReset(t);
      applyStimulus(t, 15);

      $display("[TB] random tempo sequences");
      for (int i = 0; i < 12; i++) begin
         applyStimulus($urandom_range(0, 127), $urandom_range(1, 20));
      end
      applyStimulus(int'(tempo), 12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/tempo_display.md
# tempo_display

Downstream consumer of the 7-bit free-running `tempo` count. It samples `tempo` whenever the value changes and converts it serially from binary to three BCD digits (shift-add-3). It drives a 3-digit multiplexed active-low seven-segment display and exposes the BCD result with a one-cycle valid strobe for other consumers.

## Interface
- `SCAN_BITS`, 16: width of the digit-refresh prescaler; each digit is shown for 2^SCAN_BITS clocks.
- `BLANK_ZEROS`, 1: when 1, leading zero digits are blanked; when 0, all three digits are always lit.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low. One clock domain only.
- `tempo`  in  7  binary count from the upstream counter, range 0..127, synchronous to `clk`.
- `bcd`  out  12  last converted value, registered: [11:8] hundreds (0..1), [7:4] tens, [3:0] units.
- `valid`  out  1  one-cycle pulse, coincident with each `bcd` update.
- `an`  out  3  digit enables, active-low one-hot: bit0 units, bit1 tens, bit2 hundreds.
- `seg`  out  7  segments, active-low, bit0=a … bit6=g.

## Operation
- Converter FSM with states IDLE, SHIFT, and DONE. The FSM also holds `last_tempo[6:0]`, a `force` flag, a 3-bit shift counter, and a 19-bit shift register (12 BCD bits plus 7 binary bits).
- IDLE: if `force`=1 or `tempo` != `last_tempo`:
  - load `tempo` into the binary part and zero the BCD part;
  - set `last_tempo` <= `tempo`;
  - clear `force` and the counter;
  - go to SHIFT.
- Otherwise IDLE holds.
- SHIFT: each cycle, add 3 to every BCD nibble >= 5, then shift the whole register left by 1. After the 7th shift, go to DONE.
- DONE: `bcd` <= BCD part; `valid` <= 1; go to IDLE. `valid` is 0 in every other cycle.
- `tempo` is not sampled during SHIFT or DONE. Changes in that window are caught by the IDLE comparison afterwards. With a counter that increments every clock, the result therefore shows every 9th value.
- Scan prescaler: a free-running SCAN_BITS counter. When it is all-ones, the digit index advances 0→1→2→0. Index 0 is units, 1 is tens, 2 is hundreds.
- Segment decode (g..a, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - any nibble >9 decodes to 1111111 (blank).
- Blanking when BLANK_ZEROS=1:
  - the hundreds digit is blank when it is 0;
  - the tens digit is blank when both hundreds and tens are 0;
  - the units digit is never blanked.
  - A blanked digit still asserts its `an` bit, with `seg`=1111111.

## Timing
- Reset values:
  - state IDLE, `force`=1, `last_tempo`=0
  - `bcd`=12'h000, `valid`=0
  - prescaler 0, digit index 0
  - `an`=3'b110, `seg`=7'b1000000
- If a change is captured at rising edge N (in IDLE), shifts occur at N+1..N+7, and `bcd`/`valid` update at N+8. `valid` falls at N+9.
- The next capture is possible at edge N+9 at the earliest.
- After reset release, the first edge captures `tempo` (forced). The first `valid` occurs 8 edges later, even if `tempo`=0.
- `an`/`seg` are registered: they reflect the digit index and `bcd` as of the previous edge, giving 1 cycle of latency.
- The digit index changes once per 2^SCAN_BITS clocks. A `bcd` update mid-digit appears on `seg` one clock later, with no need to wait for a digit boundary.
- Asserting `rst_n` mid-conversion immediately forces all reset values. The partial result is discarded and no `valid` is produced.

## Test plan
- Reset: hold `rst_n`=0 with `tempo`=0, then release. Required: `bcd`=000, `valid`=0, `an`=110, `seg`=1000000. Exactly one `valid` pulse at the 9th edge after release, with `bcd`=12'h000, and none thereafter.
- Hold `tempo`=127 from reset. Required: `bcd`=12'h127 with a single `valid` pulse. Repeat with `tempo`=100 (`bcd`=12'h100) and `tempo`=9 (`bcd`=12'h009).
- SCAN_BITS=2, BLANK_ZEROS=1, `tempo`=89. Required: `an` cycles 110→101→011, each held 4 clocks. `seg` shows 0010000 (units 9), then 0000000 (tens 8), then 1111111 (hundreds blank). With BLANK_ZEROS=0, the hundreds digit instead shows 1000000.
- Mid-conversion change: capture `tempo`=5 at edge N, change to 6 at N+3. Required: `bcd`=12'h005 with `valid` at N+8, then `bcd`=12'h006 with `valid` at N+17.
- Upstream counter driving `tempo`, incrementing every clock across the 127→0 wrap. Required: every `valid` pulse has `bcd` equal to the BCD of `tempo` as sampled 8 edges earlier. Consecutive `valid` pulses are exactly 9 clocks apart.
- Assert `rst_n`=0 during SHIFT. Required: outputs return to reset values asynchronously and no `valid` pulse occurs. After release, the forced conversion completes normally.
